// File: rtl/subtractor_up_pkg.sv
// Shared ALU definitions: default datapath width and the status flag bundle
// used by the adder, the subtractor and the flag register.
package subtractor_up_pkg;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic zero;
        logic neg;
        logic ovf;
        logic borrow;
    } alu_flags_t;

endpackage

// File: rtl/subtractor_up_core.sv
// Combinational ripple-borrow subtractor: a - b - bin, one full-subtractor per bit.
module subtractor_core
    import subtractor_up_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             a_msb,
    output logic             b_msb
);

    logic br;

    // Borrow ripples LSB to MSB through a scalar so the chain has no feedback net.
    always_comb begin
        diff = '0;
        br   = bin;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

    assign a_msb = a[WIDTH-1];
    assign b_msb = b[WIDTH-1];

endmodule

// File: rtl/subtractor_up.sv
// Registered subtractor: captures acc - rd - bi on in_valid and presents the
// difference, borrow-out and status flags one cycle later.
module subtractor_up
    import subtractor_up_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] acc_data,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             bi_in,
    output logic [WIDTH-1:0] sub_out,
    output logic             bi_sub,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             a_msb;
    logic             b_msb;
    alu_flags_t       flags_d;
    alu_flags_t       flags_q;
    logic [WIDTH-1:0] sub_q;
    logic             valid_q;

    subtractor_core #(.WIDTH(WIDTH)) u_core (
        .a     (acc_data),
        .b     (rd_data),
        .bin   (bi_in),
        .diff  (diff),
        .bout  (bout),
        .a_msb (a_msb),
        .b_msb (b_msb)
    );

    // Signed overflow only when operand signs differ; borrow-in is ignored.
    always_comb begin
        flags_d.zero   = (diff == '0);
        flags_d.neg    = diff[WIDTH-1];
        flags_d.ovf    = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
        flags_d.borrow = bout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sub_q   <= diff;
                flags_q <= flags_d;
            end
        end
    end

    assign sub_out   = sub_q;
    assign bi_sub    = flags_q.borrow;
    assign zero      = flags_q.zero;
    assign neg       = flags_q.neg;
    assign ovf       = flags_q.ovf;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_subtractor_up.sv
// Directed-vector bench for subtractor_up with hand-computed expectations.
module tb_subtractor_up;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] acc_data;
    logic [7:0] rd_data;
    logic       bi_in;
    logic [7:0] sub_out;
    logic       bi_sub;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       out_valid;

    int total = 0;
    int bad   = 0;

    subtractor_up #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .acc_data  (acc_data),
        .rd_data   (rd_data),
        .bi_in     (bi_in),
        .sub_out   (sub_out),
        .bi_sub    (bi_sub),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic b,
                              input logic z, input logic n, input logic o, input logic v);
        check({tag, ".sub_out"},   32'(sub_out),   32'(d));
        check({tag, ".bi_sub"},    32'(bi_sub),    32'(b));
        check({tag, ".zero"},      32'(zero),      32'(z));
        check({tag, ".neg"},       32'(neg),       32'(n));
        check({tag, ".ovf"},       32'(ovf),       32'(o));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    endtask

    // Drive one operand set, take one edge, sample 1ns after it.
    task automatic apply(input logic v, input logic [7:0] a, input logic [7:0] r, input logic bi);
        in_valid = v;
        acc_data = a;
        rd_data  = r;
        bi_in    = bi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        acc_data = 8'd45;
        rd_data  = 8'd23;
        bi_in    = 1'b0;
        #2;
        expect_out("reset", 8'd0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        expect_out("reset_edge", 8'd0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(1, 8'd0, 8'd0, 0);
        in_valid = 1'b0;

        apply(1, 8'd45, 8'd23, 0);        expect_out("45-23",   8'd22,  0, 0, 0, 0, 1);
        apply(1, 8'd23, 8'd45, 0);        expect_out("23-45",   8'hEA,  1, 0, 1, 0, 1);
        apply(1, 8'd100, 8'd100, 0);      expect_out("100-100", 8'd0,   0, 1, 0, 0, 1);
        apply(1, 8'd0, 8'd0, 1);          expect_out("0-0-1",   8'hFF,  1, 0, 1, 0, 1);
        apply(1, 8'hFF, 8'd0, 0);         expect_out("max-0",   8'hFF,  0, 0, 1, 0, 1);
        apply(1, 8'd5, 8'd3, 1);          expect_out("5-3-1",   8'd1,   0, 0, 0, 0, 1);
        apply(1, 8'h80, 8'h01, 0);        expect_out("80-01",   8'h7F,  0, 0, 0, 1, 1);
        apply(1, 8'h7F, 8'hFF, 0);        expect_out("7F-FF",   8'h80,  1, 0, 1, 1, 1);

        apply(0, 8'd10, 8'd1, 0);         expect_out("hold1",   8'h80,  1, 0, 1, 1, 0);
        apply(0, 8'd3, 8'd9, 1);          expect_out("hold2",   8'h80,  1, 0, 1, 1, 0);

        apply(1, 8'd200, 8'd50, 0);       expect_out("b2b1",    8'd150, 0, 0, 1, 0, 1);
        apply(1, 8'd50, 8'd200, 0);       expect_out("b2b2",    8'd106, 1, 0, 0, 0, 1);
        apply(1, 8'd1, 8'd2, 1);          expect_out("b2b3",    8'd254, 1, 0, 1, 0, 1);

        #2;
        rst_n = 1'b0;
        #1;
        expect_out("mid_reset", 8'd0, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        expect_out("mid_reset_edge", 8'd0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 8'd9, 8'd4, 0);          expect_out("post_idle", 8'd0, 0, 0, 0, 0, 0);
        apply(1, 8'd45, 8'd23, 0);        expect_out("post_45-23", 8'd22, 0, 0, 0, 0, 1);
        apply(0, 8'd0, 8'd0, 0);          expect_out("post_hold", 8'd22, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/subtractor_up.md
Name: subtractor_up

Overview:
- Registered unsigned/two's-complement subtractor for the generalized processor datapath.
- Computes accumulator minus operand register (acc_data − rd_data − bi_in) and returns the difference, a borrow-out and ALU status flags one clock later.
- Sits in the ALU beside the adder and feeds the accumulator write-back and flag register.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.

Ports:
- clk  in  1  system clock; rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid this cycle; capture enable.
- acc_data  in  WIDTH  minuend (accumulator).
- rd_data  in  WIDTH  subtrahend (register operand).
- bi_in  in  1  borrow-in for multi-word chaining; 0 for a plain subtract.
- sub_out  out  WIDTH  registered difference.
- bi_sub  out  1  registered borrow-out: 1 when the unsigned result is negative.
- zero  out  1  registered flag: sub_out == 0.
- neg  out  1  registered flag: sub_out[WIDTH-1].
- ovf  out  1  registered signed-overflow flag.
- out_valid  out  1  result and flags updated this cycle.

Behaviour:
- Reset: all outputs are 0 immediately on rst_n low, independent of clk. They stay 0 until the first capture after rst_n rises.
- Arithmetic (combinational core):
  - diff = acc_data − rd_data − bi_in, computed at WIDTH+1 bits.
  - sub_out = diff mod 2^WIDTH.
  - bi_sub = 1 iff acc_data < rd_data + bi_in (unsigned comparison at WIDTH+1 bits).
- Flags:
  - zero = (sub_out == 0).
  - neg = MSB of sub_out.
  - ovf = (acc[MSB] != rd[MSB]) && (sub_out[MSB] != acc[MSB]).
  - bi_in does not enter the ovf sign test.
- Latency: exactly 1 cycle. Operands present with in_valid=1 at rising edge N give results at edge N, visible for cycle N+1; out_valid=1 for that one cycle.
- When in_valid=0 at an edge:
  - sub_out, bi_sub, zero, neg and ovf hold their previous values.
  - out_valid=0.
- Back-to-back: accepts a new operand pair every cycle; no stall and no backpressure.
- Reset asserted mid-operation: any in-flight result is discarded; outputs return to 0.
- Boundaries:
  - acc == rd with bi_in=0 → 0, bi_sub=0, zero=1.
  - 0 − 0 − 1 → all ones, bi_sub=1.
  - max − 0 → max, bi_sub=0.
- No X propagation: with inputs known, the outputs are fully determined.

Decomposition:
- Shared ALU package holds:
  - default data width constant DATA_W = 8;
  - a flag struct/typedef {zero, neg, ovf, borrow} reused by the adder and the flag register.
- One sub-module, subtractor_core:
  - purely combinational ripple-borrow subtractor built from per-bit full-subtractor logic;
  - outputs diff, borrow-out and the MSB terms needed for ovf.
- Top-level subtractor_up contains only the capture registers, flag derivation and valid pipeline.

Test Plan:
- 45 − 23, bi_in=0, in_valid=1 → next cycle sub_out=22, bi_sub=0, zero=0, neg=0, ovf=0, out_valid=1.
- 23 − 45, bi_in=0 → sub_out=234 (0xEA), bi_sub=1, neg=1, ovf=0, zero=0.
- Equal and borrow-in cases:
  - 100 − 100, bi_in=0 → sub_out=0, zero=1, bi_sub=0.
  - 0 − 0, bi_in=1 → sub_out=255, bi_sub=1.
- Signed overflow: 0x80 − 0x01 → sub_out=0x7F, ovf=1, bi_sub=0, neg=0; 0x7F − 0xFF → 0x80, ovf=1, bi_sub=1.
- Hold behaviour: after a result, drive new operands with in_valid=0 → outputs unchanged, out_valid=0; then in_valid=1 for 3 consecutive cycles → 3 consecutive correct results with out_valid high each cycle.
- Reset: rst_n low between clock edges while out_valid=1 → all outputs 0 immediately; after release, the first capture produces a correct result.
